// File: rtl/exec_mult_pkg.sv
// Shared constants for the multiply execution unit, the issue queues and the CDB.
// MULT_LAT lets the issue unit plan CDB slots around the multiply pipeline depth.
package exec_mult_pkg;
  localparam int DEF_TAG_W  = 6;
  localparam int DEF_DATA_W = 32;
  localparam int MULT_LAT   = 3;
endpackage

// File: rtl/exec_mult_pipe_stage.sv
// One pipeline slot: valid, tag and payload. Loads when its advance term is set,
// otherwise holds. Cleared asynchronously by reset.
module mult_pipe_stage #(
  parameter int TAG_W = 6,
  parameter int PAY_W = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             adv,
  input  logic             v_in,
  input  logic [TAG_W-1:0] tag_in,
  input  logic [PAY_W-1:0] pay_in,
  output logic             v,
  output logic [TAG_W-1:0] tag,
  output logic [PAY_W-1:0] pay
);

  // Tag/payload only capture real entries; a bubble moving in leaves stale data behind.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v   <= 1'b0;
      tag <= '0;
      pay <= '0;
    end else if (adv) begin
      v <= v_in;
      if (v_in) begin
        tag <= tag_in;
        pay <= pay_in;
      end
    end
  end

endmodule

// File: rtl/exec_mult.sv
// Three-stage pipelined multiply unit producing the low DATA_W bits of rs*rt.
// The hi*hi partial product only affects bits >= DATA_W, so it is never formed.
module exec_mult
  import exec_mult_pkg::*;
#(
  parameter int TAG_W  = DEF_TAG_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [TAG_W-1:0]  issuemult_rdtag,
  input  logic [DATA_W-1:0] issuemult_rsdata,
  input  logic [DATA_W-1:0] issuemult_rtdata,
  input  logic              issuemult_ready,
  output logic              issuemult_done,
  output logic [TAG_W-1:0]  multcdb_tag,
  output logic [DATA_W-1:0] multcdb_data,
  output logic              multcdb_valid,
  input  logic              multcdb_ack
);

  localparam int H = DATA_W / 2;

  logic v0, v1, v2;
  logic adv0, adv1, adv2;
  logic [TAG_W-1:0] tag0, tag1, tag2;

  logic [2*DATA_W-1:0] s0_pay;
  logic [DATA_W+H-1:0] s1_pay_in, s1_pay;
  logic [DATA_W-1:0]   s2_pay_in, s2_pay;

  logic [DATA_W-1:0] rs_q, rt_q;
  logic [DATA_W-1:0] pll, s1_pll;
  logic [H-1:0]      pmid, s1_pmid;

  // Advance chain resolves back-to-front in one cycle, so a draining full pipe still accepts.
  assign adv2 = ~v2 | multcdb_ack;
  assign adv1 = ~v1 | adv2;
  assign adv0 = ~v0 | adv1;
  assign issuemult_done = issuemult_ready & adv0;

  mult_pipe_stage #(.TAG_W(TAG_W), .PAY_W(2*DATA_W)) u_s0 (
    .clk    (clk),
    .reset  (reset),
    .adv    (adv0),
    .v_in   (issuemult_ready),
    .tag_in (issuemult_rdtag),
    .pay_in ({issuemult_rsdata, issuemult_rtdata}),
    .v      (v0),
    .tag    (tag0),
    .pay    (s0_pay)
  );

  assign rs_q = s0_pay[2*DATA_W-1:DATA_W];
  assign rt_q = s0_pay[DATA_W-1:0];

  assign pll  = {{H{1'b0}}, rs_q[H-1:0]} * {{H{1'b0}}, rt_q[H-1:0]};
  assign pmid = rs_q[H-1:0] * rt_q[DATA_W-1:H] + rs_q[DATA_W-1:H] * rt_q[H-1:0];
  assign s1_pay_in = {pll, pmid};

  mult_pipe_stage #(.TAG_W(TAG_W), .PAY_W(DATA_W+H)) u_s1 (
    .clk    (clk),
    .reset  (reset),
    .adv    (adv1),
    .v_in   (v0),
    .tag_in (tag0),
    .pay_in (s1_pay_in),
    .v      (v1),
    .tag    (tag1),
    .pay    (s1_pay)
  );

  assign s1_pll    = s1_pay[DATA_W+H-1:H];
  assign s1_pmid   = s1_pay[H-1:0];
  assign s2_pay_in = s1_pll + {s1_pmid, {H{1'b0}}};

  mult_pipe_stage #(.TAG_W(TAG_W), .PAY_W(DATA_W)) u_s2 (
    .clk    (clk),
    .reset  (reset),
    .adv    (adv2),
    .v_in   (v1),
    .tag_in (tag1),
    .pay_in (s2_pay_in),
    .v      (v2),
    .tag    (tag2),
    .pay    (s2_pay)
  );

  assign multcdb_valid = v2;
  assign multcdb_tag   = tag2;
  assign multcdb_data  = s2_pay;

endmodule

// File: tb/tb_exec_mult.sv
// Bench for exec_mult: directed timing checks plus a scoreboard fed from a plain
// arithmetic model of the product; a monitor compares every presented result.
module tb_exec_mult;
  import exec_mult_pkg::*;

  localparam int TW = DEF_TAG_W;
  localparam int DW = DEF_DATA_W;

  logic          clk = 1'b0;
  logic          reset;
  logic [TW-1:0] issuemult_rdtag;
  logic [DW-1:0] issuemult_rsdata, issuemult_rtdata;
  logic          issuemult_ready;
  logic          issuemult_done;
  logic [TW-1:0] multcdb_tag;
  logic [DW-1:0] multcdb_data;
  logic          multcdb_valid;
  logic          multcdb_ack;

  typedef struct {
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  exec_mult dut (
    .clk              (clk),
    .reset            (reset),
    .issuemult_rdtag  (issuemult_rdtag),
    .issuemult_rsdata (issuemult_rsdata),
    .issuemult_rtdata (issuemult_rtdata),
    .issuemult_ready  (issuemult_ready),
    .issuemult_done   (issuemult_done),
    .multcdb_tag      (multcdb_tag),
    .multcdb_data     (multcdb_data),
    .multcdb_valid    (multcdb_valid),
    .multcdb_ack      (multcdb_ack)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] model_mul(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [2*DW-1:0] p;
    p = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
    return p[DW-1:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input int tag, input logic [DW-1:0] rs, input logic [DW-1:0] rt);
    issuemult_ready  = 1'b1;
    issuemult_rdtag  = TW'(tag);
    issuemult_rsdata = rs;
    issuemult_rtdata = rt;
  endtask

  task automatic drain();
    int n = 0;
    issuemult_ready = 1'b0;
    multcdb_ack     = 1'b1;
    while (sb.size() != 0 && n < 40) begin
      cyc();
      n++;
    end
    chk("drain_empty", 64'(sb.size()), 64'd0);
    cyc();
    @(negedge clk);
    chk("drain_idle_valid", multcdb_valid, 1'b0);
    cyc();
  endtask

  // Monitor: compare the presented head every cycle it is valid; pop on ack; push on accept.
  always @(negedge clk) begin
    if (!reset) begin
      if (multcdb_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL stale_result: got tag %0h data %0h expected no result", multcdb_tag, multcdb_data);
        end else begin
          chk("sb_tag", multcdb_tag, sb[0].tag);
          chk("sb_data", multcdb_data, sb[0].data);
          if (multcdb_ack) void'(sb.pop_front());
        end
      end
      if (issuemult_done)
        sb.push_back('{tag: issuemult_rdtag,
                       data: model_mul(issuemult_rsdata, issuemult_rtdata)});
    end
  end

  initial begin
    int accepted;
    logic [DW-1:0] corner [4];
    corner[0] = '0;
    corner[1] = 32'h1;
    corner[2] = 32'hFFFF_FFFF;
    corner[3] = 32'h0001_0000;

    reset = 1'b1;
    issuemult_ready = 1'b0;
    issuemult_rdtag = '0;
    issuemult_rsdata = '0;
    issuemult_rtdata = '0;
    multcdb_ack = 1'b0;
    #12;
    chk("rst_valid", multcdb_valid, 1'b0);
    chk("rst_tag", multcdb_tag, 0);
    chk("rst_data", multcdb_data, 0);
    chk("rst_done", issuemult_done, 1'b0);
    #1 reset = 1'b0;

    // 1: single issue, latency 3
    multcdb_ack = 1'b1;
    cyc();
    offer(5, 7, 6);
    @(negedge clk);
    chk("t1_done", issuemult_done, 1'b1);
    cyc();
    issuemult_ready = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk("t1_valid", multcdb_valid, (c == 3));
      if (c == 3) begin
        chk("t1_tag", multcdb_tag, 5);
        chk("t1_data", multcdb_data, 42);
      end
      cyc();
    end

    // 2: wrap and cross terms
    offer(6, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    cyc();
    offer(7, 32'h0001_0000, 32'h0001_0000);
    cyc();
    issuemult_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (c == 1) chk("t2_wrap", multcdb_data, 32'h1);
      if (c == 2) chk("t2_cross", multcdb_data, 32'h0);
      cyc();
    end
    drain();

    // 3: back-to-back with ack held
    for (int c = 0; c < 8; c++) begin
      if (c < 4) offer(c + 1, $urandom, $urandom);
      else issuemult_ready = 1'b0;
      @(negedge clk);
      if (c < 4) chk("t3_done", issuemult_done, 1'b1);
      chk("t3_valid", multcdb_valid, (c >= 3 && c <= 6));
      if (c >= 3 && c <= 6) chk("t3_tag", multcdb_tag, c - 2);
      cyc();
    end
    drain();

    // 4: back-pressure
    multcdb_ack = 1'b0;
    accepted = 0;
    for (int c = 0; c < 6; c++) begin
      offer(10 + accepted, $urandom, $urandom);
      @(negedge clk);
      chk("t4_done", issuemult_done, (c < 3));
      if (c >= 3) chk("t4_hold_tag", multcdb_tag, 10);
      if (issuemult_done) accepted++;
      cyc();
    end
    multcdb_ack = 1'b1;
    @(negedge clk);
    chk("t4_ack_done", issuemult_done, 1'b1);
    cyc();
    multcdb_ack = 1'b0;
    issuemult_ready = 1'b0;
    @(negedge clk);
    chk("t4_next_valid", multcdb_valid, 1'b1);
    chk("t4_next_tag", multcdb_tag, 11);
    cyc();
    drain();

    // 5: bubble collapse
    multcdb_ack = 1'b0;
    offer(8, $urandom, $urandom);
    @(negedge clk);
    chk("t5_done_a", issuemult_done, 1'b1);
    cyc();
    issuemult_ready = 1'b0;
    @(negedge clk);
    cyc();
    offer(9, $urandom, $urandom);
    @(negedge clk);
    chk("t5_done_b", issuemult_done, 1'b1);
    cyc();
    offer(20, $urandom, $urandom);
    @(negedge clk);
    chk("t5_done_c", issuemult_done, 1'b1);
    cyc();
    @(negedge clk);
    chk("t5_full_done", issuemult_done, 1'b0);
    chk("t5_head_tag", multcdb_tag, 8);
    cyc();
    issuemult_ready = 1'b0;
    multcdb_ack = 1'b1;
    @(negedge clk);
    cyc();
    multcdb_ack = 1'b0;
    @(negedge clk);
    chk("t5_adjacent_tag", multcdb_tag, 9);
    cyc();
    drain();

    // 6: async reset mid-flight
    multcdb_ack = 1'b0;
    offer(30, $urandom, $urandom);
    cyc();
    offer(31, $urandom, $urandom);
    cyc();
    issuemult_ready = 1'b0;
    cyc();
    chk("t6_pre_valid", multcdb_valid, 1'b1);
    #2 reset = 1'b1;
    issuemult_ready = 1'b1;
    #1;
    chk("t6_rst_valid", multcdb_valid, 1'b0);
    chk("t6_rst_tag", multcdb_tag, 0);
    chk("t6_rst_data", multcdb_data, 0);
    chk("t6_rst_done", issuemult_done, 1'b1);
    sb.delete();
    issuemult_ready = 1'b0;
    @(posedge clk);
    #3 reset = 1'b0;
    multcdb_ack = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("t6_no_stale", multcdb_valid, 1'b0);
      cyc();
    end
    offer(33, 32'd1234, 32'd5678);
    @(negedge clk);
    chk("t6_new_done", issuemult_done, 1'b1);
    cyc();
    drain();

    // 7: randomized traffic with random back-pressure
    for (int c = 0; c < 400; c++) begin
      issuemult_ready  = ($urandom_range(0, 3) != 0);
      issuemult_rdtag  = TW'($urandom);
      issuemult_rsdata = ($urandom_range(0, 4) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
      issuemult_rtdata = ($urandom_range(0, 4) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
      multcdb_ack      = ($urandom_range(0, 9) < 7);
      cyc();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
